// File: rtl/rho_peak_find.sv
// rho_peak_find: streams NBIN-sample segments of unsigned rho values and
// reports, once per completed segment, the maximum sample, its index within
// the segment, whether it reaches the threshold, and a wrapping segment
// number. Gaps (in_vld low) are transparent; in_clr aborts a partial segment.
module rho_peak_find #(
   parameter int DW   = 28,
   parameter int NBIN = 256,
   parameter int IW   = 8,
   parameter int SW   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_vld,
   input  logic [DW-1:0] in_data,
   input  logic          in_clr,
   input  logic [DW-1:0] thresh,
   output logic          busy,
   output logic          out_vld,
   output logic [DW-1:0] out_max,
   output logic [IW-1:0] out_idx,
   output logic          out_hit,
   output logic [SW-1:0] out_seg
);

   typedef enum logic {IDLE, ACC} state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(NBIN - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [DW-1:0] max_q, max_d;
   logic [IW-1:0] arg_q, arg_d;
   logic [SW-1:0] seg_q, seg_d;
   logic          out_vld_q, out_vld_d;
   logic [DW-1:0] out_max_q, out_max_d;
   logic [IW-1:0] out_idx_q, out_idx_d;
   logic          out_hit_q, out_hit_d;
   logic [SW-1:0] out_seg_q, out_seg_d;

   logic          accept;
   logic          is_last;
   logic          take;
   logic [DW-1:0] max_new;
   logic [IW-1:0] arg_new;

   // Running-max update: idx 0 always loads (no carry-over between segments);
   // later samples win only when strictly greater, so ties keep the earliest.
   always_comb begin
      accept  = in_vld & ~in_clr;
      is_last = accept && (idx_q == LAST_IDX);
      take    = (idx_q == '0) || (in_data > max_q);
      max_new = take ? in_data : max_q;
      arg_new = take ? idx_q : arg_q;
   end

   // Next-state: in_clr dominates, then accepted samples advance the segment;
   // gaps leave everything untouched. Result fields hold between pulses.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      max_d     = max_q;
      arg_d     = arg_q;
      seg_d     = seg_q;
      out_vld_d = 1'b0;
      out_max_d = out_max_q;
      out_idx_d = out_idx_q;
      out_hit_d = out_hit_q;
      out_seg_d = out_seg_q;
      if (in_clr) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (accept) begin
         max_d = max_new;
         arg_d = arg_new;
         if (is_last) begin
            // segment complete: publish including this sample, restart at idx 0
            state_d   = IDLE;
            idx_d     = '0;
            out_vld_d = 1'b1;
            out_max_d = max_new;
            out_idx_d = arg_new;
            out_hit_d = (max_new >= thresh);
            out_seg_d = seg_q;
            seg_d     = seg_q + SW'(1);
         end else begin
            state_d = ACC;
            idx_d   = idx_q + IW'(1);
         end
      end
   end

   // State and result registers; everything clears on reset, dropping any
   // partial segment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         max_q     <= '0;
         arg_q     <= '0;
         seg_q     <= '0;
         out_vld_q <= 1'b0;
         out_max_q <= '0;
         out_idx_q <= '0;
         out_hit_q <= 1'b0;
         out_seg_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         max_q     <= max_d;
         arg_q     <= arg_d;
         seg_q     <= seg_d;
         out_vld_q <= out_vld_d;
         out_max_q <= out_max_d;
         out_idx_q <= out_idx_d;
         out_hit_q <= out_hit_d;
         out_seg_q <= out_seg_d;
      end
   end

   assign busy    = (state_q == ACC);
   assign out_vld = out_vld_q;
   assign out_max = out_max_q;
   assign out_idx = out_idx_q;
   assign out_hit = out_hit_q;
   assign out_seg = out_seg_q;

endmodule

// File: tb/tb_rho_peak_find.sv
// Directed bench for rho_peak_find with NBIN=4. Inputs change and outputs are
// sampled on the falling edge; expected values are hand-computed.
module tb_rho_peak_find;

   localparam int DW = 28;
   localparam int NBIN = 4;
   localparam int IW = 2;
   localparam int SW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_vld;
   logic [DW-1:0] in_data;
   logic          in_clr;
   logic [DW-1:0] thresh;
   logic          busy;
   logic          out_vld;
   logic [DW-1:0] out_max;
   logic [IW-1:0] out_idx;
   logic          out_hit;
   logic [SW-1:0] out_seg;

   int n_cmp = 0;
   int n_bad = 0;

   rho_peak_find #(.DW(DW), .NBIN(NBIN), .IW(IW), .SW(SW)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
      .in_clr(in_clr), .thresh(thresh), .busy(busy), .out_vld(out_vld),
      .out_max(out_max), .out_idx(out_idx), .out_hit(out_hit), .out_seg(out_seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock with the given inputs; returns at the following falling edge
   task automatic step(input logic v, input logic [DW-1:0] d, input logic c);
      in_vld  = v;
      in_data = d;
      in_clr  = c;
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      in_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, '0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_vld = 1'b0; in_data = '0; in_clr = 1'b0; thresh = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_vld",  32'(out_vld), 0);
      chk("rst_max",  32'(out_max), 0);
      chk("rst_idx",  32'(out_idx), 0);
      chk("rst_hit",  32'(out_hit), 0);
      chk("rst_seg",  32'(out_seg), 0);
      rst = 1'b0;

      // 5,9,3,9 thresh 8: tie keeps idx 1
      thresh = 28'd8;
      step(1, 5, 0); chk("t1_busy", 32'(busy), 1);
      step(1, 9, 0);
      step(1, 3, 0); chk("t1_vld_early", 32'(out_vld), 0);
      step(1, 9, 0);
      chk("t1_vld", 32'(out_vld), 1);
      chk("t1_max", 32'(out_max), 9);
      chk("t1_idx", 32'(out_idx), 1);
      chk("t1_hit", 32'(out_hit), 1);
      chk("t1_seg", 32'(out_seg), 0);
      chk("t1_busy_end", 32'(busy), 0);
      step(0, 0, 0);
      chk("t1_pulse_1clk", 32'(out_vld), 0);
      chk("t1_hold_max", 32'(out_max), 9);
      chk("t1_hold_idx", 32'(out_idx), 1);

      // 7,1,1,1 then 2,2,2,2 back-to-back, thresh 10
      do_reset();
      thresh = 28'd10;
      step(1, 7, 0); step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
      chk("t2a_vld", 32'(out_vld), 1);
      chk("t2a_max", 32'(out_max), 7);
      chk("t2a_idx", 32'(out_idx), 0);
      chk("t2a_hit", 32'(out_hit), 0);
      chk("t2a_seg", 32'(out_seg), 0);
      step(1, 2, 0);
      chk("t2_no_bubble_busy", 32'(busy), 1);
      chk("t2_gap_vld", 32'(out_vld), 0);
      step(1, 2, 0); step(1, 2, 0);
      chk("t2_gap_vld2", 32'(out_vld), 0);
      step(1, 2, 0);
      chk("t2b_vld", 32'(out_vld), 1);
      chk("t2b_max", 32'(out_max), 2);
      chk("t2b_idx", 32'(out_idx), 0);
      chk("t2b_hit", 32'(out_hit), 0);
      chk("t2b_seg", 32'(out_seg), 1);

      // gaps: 1,_,_,8,_,4,6
      do_reset();
      thresh = 28'd8;
      step(1, 1, 0); chk("t3_busy0", 32'(busy), 1);
      step(0, 50, 0); step(0, 60, 0);
      chk("t3_busy_gap", 32'(busy), 1);
      step(1, 8, 0);
      step(0, 70, 0);
      chk("t3_busy_gap2", 32'(busy), 1);
      step(1, 4, 0);
      chk("t3_vld_early", 32'(out_vld), 0);
      step(1, 6, 0);
      chk("t3_vld", 32'(out_vld), 1);
      chk("t3_max", 32'(out_max), 8);
      chk("t3_idx", 32'(out_idx), 1);
      chk("t3_hit", 32'(out_hit), 1);
      chk("t3_busy_end", 32'(busy), 0);

      // in_clr with in_vld (99 dropped), then 2,2,2,1
      do_reset();
      thresh = 28'd100;
      step(1, 3, 0); step(1, 4, 0);
      step(1, 99, 1);
      chk("t4_clr_busy", 32'(busy), 0);
      chk("t4_clr_vld", 32'(out_vld), 0);
      step(0, 0, 1);
      chk("t4_idle_clr_busy", 32'(busy), 0);
      step(1, 2, 0); step(1, 2, 0); step(1, 2, 0);
      chk("t4_vld_early", 32'(out_vld), 0);
      step(1, 1, 0);
      chk("t4_vld", 32'(out_vld), 1);
      chk("t4_max", 32'(out_max), 2);
      chk("t4_idx", 32'(out_idx), 0);
      chk("t4_hit", 32'(out_hit), 0);
      chk("t4_seg", 32'(out_seg), 0);

      // reset mid-segment
      do_reset();
      thresh = 28'd6;
      step(1, 3, 0); step(1, 7, 0);
      do_reset();
      chk("t5_rst_busy", 32'(busy), 0);
      step(1, 6, 0); step(1, 0, 0); step(1, 0, 0);
      chk("t5_vld_early", 32'(out_vld), 0);
      step(1, 0, 0);
      chk("t5_vld", 32'(out_vld), 1);
      chk("t5_max", 32'(out_max), 6);
      chk("t5_idx", 32'(out_idx), 0);
      chk("t5_hit", 32'(out_hit), 1);
      chk("t5_seg", 32'(out_seg), 0);

      // 257 segments: segment counter wraps; full-width max at idx 2
      do_reset();
      thresh = 28'h0FFFFFFF;
      for (int k = 0; k < 257; k++) begin
         step(1, 28'h0FFFFFFE, 0);
         step(1, 28'h1, 0);
         step(1, 28'h0FFFFFFF, 0);
         step(1, 28'h0FFFFFFF, 0);
         chk("t6_vld", 32'(out_vld), 1);
         chk("t6_seg", 32'(out_seg), 32'(k % 256));
         if (k == 0 || k == 255 || k == 256) begin
            chk("t6_max", 32'(out_max), 32'h0FFFFFFF);
            chk("t6_idx", 32'(out_idx), 2);
            chk("t6_hit", 32'(out_hit), 1);
         end
      end

      // threshold one above the max: not a hit
      thresh = 28'd10;
      step(1, 9, 0); step(1, 9, 0); step(1, 9, 0); step(1, 9, 0);
      chk("t7_hit", 32'(out_hit), 0);
      chk("t7_seg", 32'(out_seg), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rho_peak_find.md
RHO_PEAK_FIND -- requirements
Module: rho_peak_find

Interface
REQ-001 Parameter DW, default 28, width of each accumulator/rho sample.
REQ-002 Parameter NBIN, default 256, samples per segment (one phase); legal range 2..4096.
REQ-003 Parameter IW, default 8, index width; SHALL satisfy 2^IW >= NBIN.
REQ-004 Parameter SW, default 8, segment-counter width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_vld  input  1  in_data valid this cycle; low = gap, no sample.
REQ-008 in_data  input  DW  unsigned sample.
REQ-009 in_clr  input  1  synchronous abort of the current partial segment.
REQ-010 thresh  input  DW  unsigned peak-qualification threshold.
REQ-011 busy  output  1  high while a segment is partially received (state ACC).
REQ-012 out_vld  output  1  one-cycle pulse, result fields valid.
REQ-013 out_max  output  DW  maximum sample of the completed segment.
REQ-014 out_idx  output  IW  index (0..NBIN-1) of that maximum.
REQ-015 out_hit  output  1  out_max >= thresh.
REQ-016 out_seg  output  SW  completed-segment number, modulo 2^SW.

Function
REQ-017 States: IDLE (no sample held, idx=0) and ACC (1..NBIN-1 samples held).
REQ-018 Accepted sample = in_vld high and in_clr low; idx counts accepted samples 0..NBIN-1.
REQ-019 Gaps (in_vld low) SHALL NOT advance idx, change state or alter the running max.
REQ-020 Sample idx 0 SHALL load the running max and argmax unconditionally; no value carries over between segments.
REQ-021 Later samples replace the running max only if strictly greater; ties keep the earliest index.
REQ-022 IDLE->ACC on accepted sample when NBIN>1; ACC->IDLE when sample idx NBIN-1 is accepted or in_clr is high.
REQ-023 On the edge accepting sample NBIN-1, out_max/out_idx SHALL register the max including that sample; out_vld high for exactly the following cycle (latency 1 clock).
REQ-024 out_hit SHALL be computed against thresh sampled on the same edge as out_max.
REQ-025 out_seg SHALL carry the current segment count with out_vld, then increment; it wraps 2^SW-1 -> 0.
REQ-026 out_max, out_idx, out_hit and out_seg SHALL hold their values between out_vld pulses.
REQ-027 Back-to-back segments: sample idx 0 of the next segment is accepted on the cycle immediately after sample NBIN-1, with no bubble.
REQ-028 in_clr: idx->0, state->IDLE, partial discarded, no out_vld, out_seg unchanged; in_clr wins over a simultaneous in_vld, and that sample is dropped.
REQ-029 in_clr in IDLE is a no-op.
REQ-030 Comparisons are unsigned, full DW width; no saturation or truncation.

Reset
REQ-031 While rst is high: state IDLE, idx 0, busy 0, out_vld 0, out_max 0, out_idx 0, out_hit 0, out_seg 0, running max/argmax 0.
REQ-032 Reset mid-segment SHALL discard the partial segment; the first accepted sample after release is idx 0.
REQ-033 Reset deassertion is synchronised externally; the block SHALL accept a sample on the first edge after release.

Verification (NBIN=4, DW=28, IW=2, SW=8)
REQ-034 Samples 5,9,3,9 contiguous, thresh=8 -> one out_vld pulse 1 clk after 4th sample; out_max=9, out_idx=1, out_hit=1, out_seg=0.
REQ-035 Segment 7,1,1,1, then 2,2,2,2 back-to-back, thresh=10 -> pulses 4 clk apart; first (7,0,hit 0,seg 0), second (2,0,hit 0,seg 1), confirming no carry-over.
REQ-036 Samples 1,_,_,8,_,4,6 with gaps (_ = in_vld low) -> out_max=8, out_idx=1; busy high from first sample until the pulse.
REQ-037 Samples 3,4 then in_clr together with in_vld (data 99), then 2,2,2,1 -> single pulse out_max=2, out_idx=0; the value 99 is never reported.
REQ-038 rst asserted after 2 samples, released, then 6,0,0,0 -> out_max=6, out_idx=0, out_seg=0.
REQ-039 256 full segments -> out_seg runs 0..255 and then reads 0 on segment 257; sample 0x0FFFFFFF is reported as max without truncation.
